// File: rtl/sprite_rom_arbiter.sv
// -----------------------------------------------------------------------------
// sprite_rom_arbiter
//   Shares one synchronous sprite ROM between two pixel-fetch requesters.
//   Port 0 is the character sprite renderer and port 1 is the
//   background/platform renderer. At most one ROM read is granted per cycle.
//   Reads are pipelined, and each returned word is tagged back to the port
//   that issued it.
//
//   Compile-time option:
//     SPRITE_ARB_CHAR_PRIORITY_EN
//       Defined:   port 0 wins ties, except after port 1 has lost
//                  STARVE_LIMIT times in a row.
//       Undefined: pure round-robin on ties.
//
// Ports
//   sys_clk            system clock
//   sys_rst            synchronous reset, active-high
//   req0/addr0         port 0 read request and address, held until ack0
//   ack0               port 0 request accepted this cycle (combinational)
//   rvalid0/rdata0     port 0 read return, one-cycle pulse; data holds between pulses
//   req1/addr1/ack1/rvalid1/rdata1   same for port 1
//   rom_en/rom_addr    registered ROM read strobe and address
//   rom_data           ROM output, valid ROM_LATENCY cycles after rom_en
// -----------------------------------------------------------------------------
module sprite_rom_arbiter #(
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 12,
    parameter int ROM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  req0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    output logic                  ack0,
    output logic                  rvalid0,
    output logic [DATA_WIDTH-1:0] rdata0,
    input  logic                  req1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic                  ack1,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  rom_en,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data
);

    // rom_en/rom_port_r act as the issue stage. The tag line then follows the
    // read through the ROM latency plus the rom_data capture register.
    localparam int TAG_DEPTH = ROM_LATENCY + 1;

    if (ROM_LATENCY < 1 || ROM_LATENCY > 4 || STARVE_LIMIT < 1) begin : g_param_check
        $error("sprite_rom_arbiter: ROM_LATENCY must be 1..4 and STARVE_LIMIT >= 1");
    end

    logic                  tie_to_1_s;
    logic                  rom_port_r;
    logic [TAG_DEPTH-1:0]  tag_valid_r;
    logic [TAG_DEPTH-1:0]  tag_port_r;
    logic [DATA_WIDTH-1:0] rom_data_r;
    logic                  ret0_s;
    logic                  ret1_s;

`ifdef SPRITE_ARB_CHAR_PRIORITY_EN
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    logic [STARVE_W-1:0] starve_cnt_r;

    // Port 0 owns ties until port 1 has been starved long enough.
    always_comb begin
        tie_to_1_s = (starve_cnt_r == STARVE_MAX);
    end

    // Count consecutive port-1 losses. The count saturates at the limit.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            starve_cnt_r <= {STARVE_W{1'b0}};
        end else if (ack1) begin
            starve_cnt_r <= {STARVE_W{1'b0}};
        end else if (req1 && (starve_cnt_r != STARVE_MAX)) begin
            starve_cnt_r <= starve_cnt_r + STARVE_W'(1);
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end
`else
    logic last_grant_r;

    // Round-robin: on a tie, the port that did not win last time wins now.
    always_comb begin
        tie_to_1_s = ~last_grant_r;
    end

    // Remember the last accepted port. Requests that are withdrawn leave it alone.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            last_grant_r <= 1'b1;
        end else if (ack0) begin
            last_grant_r <= 1'b0;
        end else if (ack1) begin
            last_grant_r <= 1'b1;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end
`endif

    // Same-cycle grant. The two acks are mutually exclusive and both are held low in reset.
    always_comb begin
        ack0 = 1'b0;
        ack1 = 1'b0;
        if (sys_rst) begin
            ack0 = 1'b0;
            ack1 = 1'b0;
        end else if (req0 && req1) begin
            ack0 = ~tie_to_1_s;
            ack1 = tie_to_1_s;
        end else begin
            ack0 = req0;
            ack1 = req1;
        end
    end

    // Issue stage. An accepted transfer drives the ROM strobe. rom_addr keeps its value when idle.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rom_en     <= 1'b0;
            rom_addr   <= {ADDR_WIDTH{1'b0}};
            rom_port_r <= 1'b0;
        end else if (ack0 || ack1) begin
            rom_en     <= 1'b1;
            rom_addr   <= ack1 ? addr1 : addr0;
            rom_port_r <= ack1;
        end else begin
            rom_en     <= 1'b0;
            rom_addr   <= rom_addr;
            rom_port_r <= rom_port_r;
        end
    end

    // Tag line that follows every in-flight read. Reset drops all pending reads.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            tag_valid_r <= {TAG_DEPTH{1'b0}};
            tag_port_r  <= {TAG_DEPTH{1'b0}};
        end else begin
            tag_valid_r <= {tag_valid_r[TAG_DEPTH-2:0], rom_en};
            tag_port_r  <= {tag_port_r[TAG_DEPTH-2:0], rom_port_r};
        end
    end

    // Capture register for the ROM output, one cycle after its data becomes valid.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rom_data_r <= {DATA_WIDTH{1'b0}};
        end else begin
            rom_data_r <= rom_data;
        end
    end

    // Steer the returning word to its owner, using the oldest tag entry.
    always_comb begin
        ret0_s = 1'b0;
        ret1_s = 1'b0;
        if (tag_valid_r[TAG_DEPTH-1]) begin
            ret0_s = ~tag_port_r[TAG_DEPTH-1];
            ret1_s = tag_port_r[TAG_DEPTH-1];
        end else begin
            ret0_s = 1'b0;
            ret1_s = 1'b0;
        end
    end

    // Registered return ports. Read data holds between valid pulses.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata0  <= {DATA_WIDTH{1'b0}};
            rdata1  <= {DATA_WIDTH{1'b0}};
        end else begin
            rvalid0 <= ret0_s;
            rvalid1 <= ret1_s;
            rdata0  <= ret0_s ? rom_data_r : rdata0;
            rdata1  <= ret1_s ? rom_data_r : rdata1;
        end
    end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
`timescale 1ns/1ps
module tb_sprite_rom_arbiter;

    localparam int AW = 12;
    localparam int DW = 12;
    localparam int RL = 2;

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic          req0 = 1'b0, req1 = 1'b0;
    logic [AW-1:0] addr0 = 12'h000, addr1 = 12'h000;
    logic          ack0, ack1, rvalid0, rvalid1, rom_en;
    logic [DW-1:0] rdata0, rdata1, rom_data;
    logic [AW-1:0] rom_addr;

    logic          req_b0 = 1'b0, req_b1 = 1'b0;
    logic [AW-1:0] addr_b0 = 12'h000, addr_b1 = 12'h000;
    logic          l1_ack0, l1_ack1, l1_rvalid0, l1_rvalid1, l1_rom_en;
    logic [DW-1:0] l1_rdata0, l1_rdata1, l1_rom_data;
    logic [AW-1:0] l1_rom_addr;
    logic          l4_ack0, l4_ack1, l4_rvalid0, l4_rvalid1, l4_rom_en;
    logic [DW-1:0] l4_rdata0, l4_rdata1, l4_rom_data;
    logic [AW-1:0] l4_rom_addr;

    int checks = 0;
    int errors = 0;

    logic [9:0]    grant_pat;
    logic          ev [0:31];
    logic          ep [0:31];
    logic [DW-1:0] ed [0:31];
    logic          e1v [0:31];
    logic          e1p [0:31];
    logic [DW-1:0] e1d [0:31];
    logic          e4v [0:31];
    logic          e4p [0:31];
    logic [DW-1:0] e4d [0:31];

    always #5 sys_clk = ~sys_clk;

    sprite_rom_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROM_LATENCY(RL), .STARVE_LIMIT(4)) u_dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .req0(req0), .addr0(addr0), .ack0(ack0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .addr1(addr1), .ack1(ack1), .rvalid1(rvalid1), .rdata1(rdata1),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data));

    sprite_rom_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROM_LATENCY(1), .STARVE_LIMIT(4)) u_dut_l1 (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .req0(req_b0), .addr0(addr_b0), .ack0(l1_ack0), .rvalid0(l1_rvalid0), .rdata0(l1_rdata0),
        .req1(req_b1), .addr1(addr_b1), .ack1(l1_ack1), .rvalid1(l1_rvalid1), .rdata1(l1_rdata1),
        .rom_en(l1_rom_en), .rom_addr(l1_rom_addr), .rom_data(l1_rom_data));

    sprite_rom_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROM_LATENCY(4), .STARVE_LIMIT(4)) u_dut_l4 (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .req0(req_b0), .addr0(addr_b0), .ack0(l4_ack0), .rvalid0(l4_rvalid0), .rdata0(l4_rdata0),
        .req1(req_b1), .addr1(addr_b1), .ack1(l4_ack1), .rvalid1(l4_rvalid1), .rdata1(l4_rdata1),
        .rom_en(l4_rom_en), .rom_addr(l4_rom_addr), .rom_data(l4_rom_data));

    // ROM contents: a fixed scramble of the address
    function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
        return {a[5:0], a[11:6]} ^ 12'hA5C;
    endfunction

    // Synchronous ROM models: rom_en is sampled at an edge, and data appears after LAT edges
    logic [DW-1:0] rp2 [0:1];
    logic [DW-1:0] rp1;
    logic [DW-1:0] rp4 [0:3];
    always @(posedge sys_clk) begin
        rp2[0] <= rom_en ? rom_fn(rom_addr) : 12'h000;
        rp2[1] <= rp2[0];
        rp1    <= l1_rom_en ? rom_fn(l1_rom_addr) : 12'h000;
        rp4[0] <= l4_rom_en ? rom_fn(l4_rom_addr) : 12'h000;
        rp4[1] <= rp4[0];
        rp4[2] <= rp4[1];
        rp4[3] <= rp4[2];
    end
    assign rom_data    = rp2[1];
    assign l1_rom_data = rp1;
    assign l4_rom_data = rp4[3];

    task automatic clear_exp();
        for (int k = 0; k < 32; k++) begin
            ev[k] = 1'b0; ep[k] = 1'b0; ed[k] = 12'h000;
            e1v[k] = 1'b0; e1p[k] = 1'b0; e1d[k] = 12'h000;
            e4v[k] = 1'b0; e4p[k] = 1'b0; e4d[k] = 12'h000;
        end
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst = 1'b1; req0 = 1'b0; req1 = 1'b0; req_b0 = 1'b0; req_b1 = 1'b0;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        clear_exp();
    endtask

    task automatic test_reset();
        @(negedge sys_clk);
        checks++;
        if (rom_en !== 1'b0 || rom_addr !== 12'h000) begin
            errors++; $display("FAIL reset_rom got en=%0b addr=%h exp en=0 addr=000", rom_en, rom_addr);
        end
        checks++;
        if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0 || rdata0 !== 12'h000 || rdata1 !== 12'h000) begin
            errors++; $display("FAIL reset_ret got v0=%0b v1=%0b d0=%h d1=%h exp all 0", rvalid0, rvalid1, rdata0, rdata1);
        end
        req0 = 1'b1; req1 = 1'b1; addr0 = 12'h0AA; addr1 = 12'h0BB;
        #1;
        checks++;
        if (ack0 !== 1'b0 || ack1 !== 1'b0) begin
            errors++; $display("FAIL reset_ack got ack0=%0b ack1=%0b exp 0 0", ack0, ack1);
        end
        @(negedge sys_clk);
        checks++;
        if (rom_en !== 1'b0) begin
            errors++; $display("FAIL reset_hold_en got %0b exp 0", rom_en);
        end
        sys_rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic test_single_read();
        for (int i = 0; i < 9; i++) begin
            @(negedge sys_clk);
            if (i == 1) begin
                checks++;
                if (rom_en !== 1'b1 || rom_addr !== 12'h010) begin
                    errors++; $display("FAIL single_issue got en=%0b addr=%h exp en=1 addr=010", rom_en, rom_addr);
                end
            end
            if (i == 2) begin
                checks++;
                if (rom_en !== 1'b0 || rom_addr !== 12'h010) begin
                    errors++; $display("FAIL single_idle got en=%0b addr=%h exp en=0 addr=010", rom_en, rom_addr);
                end
            end
            checks++;
            if (rvalid0 !== (i == RL + 3) || rvalid1 !== 1'b0) begin
                errors++; $display("FAIL single_rvalid cyc %0d got v0=%0b v1=%0b exp v0=%0b v1=0", i, rvalid0, rvalid1, (i == RL + 3));
            end
            if (i >= RL + 3) begin
                checks++;
                if (rdata0 !== rom_fn(12'h010)) begin
                    errors++; $display("FAIL single_rdata cyc %0d got %h exp %h", i, rdata0, rom_fn(12'h010));
                end
            end
            if (i == 0) begin
                req0 = 1'b1; addr0 = 12'h010;
                #1;
                checks++;
                if (ack0 !== 1'b1 || ack1 !== 1'b0) begin
                    errors++; $display("FAIL single_ack got ack0=%0b ack1=%0b exp 1 0", ack0, ack1);
                end
            end else begin
                req0 = 1'b0;
            end
        end
    endtask

    task automatic test_round_robin();
        logic gp;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            @(negedge sys_clk);
            checks++;
            if (rvalid0 !== (ev[i] & ~ep[i]) || rvalid1 !== (ev[i] & ep[i])) begin
                errors++; $display("FAIL rr_rvalid cyc %0d got v0=%0b v1=%0b exp v0=%0b v1=%0b", i, rvalid0, rvalid1, ev[i] & ~ep[i], ev[i] & ep[i]);
            end
            if (ev[i]) begin
                checks++;
                if ((ep[i] ? rdata1 : rdata0) !== ed[i]) begin
                    errors++; $display("FAIL rr_rdata cyc %0d got %h exp %h", i, (ep[i] ? rdata1 : rdata0), ed[i]);
                end
            end
            if (i < 8) begin
                req0 = 1'b1; req1 = 1'b1; addr0 = 12'h100; addr1 = 12'h200;
                #1;
                gp = grant_pat[i];
                checks++;
                if (ack0 !== ~gp || ack1 !== gp) begin
                    errors++; $display("FAIL rr_ack cyc %0d got ack0=%0b ack1=%0b exp %0b %0b", i, ack0, ack1, ~gp, gp);
                end
                ev[i + RL + 3] = 1'b1; ep[i + RL + 3] = gp;
                ed[i + RL + 3] = rom_fn(gp ? 12'h200 : 12'h100);
            end else begin
                req0 = 1'b0; req1 = 1'b0;
            end
        end
    endtask

    task automatic test_latency_sweep();
        logic          gp;
        logic [AW-1:0] a0, a1;
        int            n1, n4;
        a0 = 12'h100; a1 = 12'h200; n1 = 0; n4 = 0;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge sys_clk);
            n1 = n1 + int'(l1_rvalid0) + int'(l1_rvalid1);
            n4 = n4 + int'(l4_rvalid0) + int'(l4_rvalid1);
            checks++;
            if (l1_rvalid0 !== (e1v[i] & ~e1p[i]) || l1_rvalid1 !== (e1v[i] & e1p[i])) begin
                errors++; $display("FAIL lat1_rvalid cyc %0d got %0b%0b exp %0b%0b", i, l1_rvalid1, l1_rvalid0, e1v[i] & e1p[i], e1v[i] & ~e1p[i]);
            end
            if (e1v[i]) begin
                checks++;
                if ((e1p[i] ? l1_rdata1 : l1_rdata0) !== e1d[i]) begin
                    errors++; $display("FAIL lat1_rdata cyc %0d got %h exp %h", i, (e1p[i] ? l1_rdata1 : l1_rdata0), e1d[i]);
                end
            end
            checks++;
            if (l4_rvalid0 !== (e4v[i] & ~e4p[i]) || l4_rvalid1 !== (e4v[i] & e4p[i])) begin
                errors++; $display("FAIL lat4_rvalid cyc %0d got %0b%0b exp %0b%0b", i, l4_rvalid1, l4_rvalid0, e4v[i] & e4p[i], e4v[i] & ~e4p[i]);
            end
            if (e4v[i]) begin
                checks++;
                if ((e4p[i] ? l4_rdata1 : l4_rdata0) !== e4d[i]) begin
                    errors++; $display("FAIL lat4_rdata cyc %0d got %h exp %h", i, (e4p[i] ? l4_rdata1 : l4_rdata0), e4d[i]);
                end
            end
            if (i < 8) begin
                req_b0 = 1'b1; req_b1 = 1'b1; addr_b0 = a0; addr_b1 = a1;
                #1;
                gp = grant_pat[i];
                checks++;
                if (l1_ack0 !== ~gp || l1_ack1 !== gp || l4_ack0 !== ~gp || l4_ack1 !== gp) begin
                    errors++; $display("FAIL lat_ack cyc %0d got l1=%0b%0b l4=%0b%0b exp ack1/ack0=%0b%0b", i, l1_ack1, l1_ack0, l4_ack1, l4_ack0, gp, ~gp);
                end
                e1v[i + 4] = 1'b1; e1p[i + 4] = gp; e1d[i + 4] = rom_fn(gp ? a1 : a0);
                e4v[i + 7] = 1'b1; e4p[i + 7] = gp; e4d[i + 7] = rom_fn(gp ? a1 : a0);
                if (gp) a1 = a1 + 12'h001;
                else    a0 = a0 + 12'h001;
            end else begin
                req_b0 = 1'b0; req_b1 = 1'b0;
            end
        end
        checks++;
        if (n1 != 8 || n4 != 8) begin
            errors++; $display("FAIL lat_count got l1=%0d l4=%0d exp 8 8", n1, n4);
        end
    endtask

    task automatic test_reset_in_flight();
        do_reset();
        for (int i = 0; i < 12; i++) begin
            @(negedge sys_clk);
            checks++;
            if (rvalid0 !== (i == 4 + RL + 3) || rvalid1 !== 1'b0) begin
                errors++; $display("FAIL rif_rvalid cyc %0d got v0=%0b v1=%0b exp v0=%0b v1=0", i, rvalid0, rvalid1, (i == 4 + RL + 3));
            end
            if (i == 4 + RL + 3) begin
                checks++;
                if (rdata0 !== rom_fn(12'h4A0)) begin
                    errors++; $display("FAIL rif_rdata got %h exp %h", rdata0, rom_fn(12'h4A0));
                end
            end
            if (i == 4) begin
                checks++;
                if (rom_en !== 1'b0) begin
                    errors++; $display("FAIL rif_rom_en got %0b exp 0", rom_en);
                end
            end
            if (i < 3) begin
                req0 = 1'b1; req1 = 1'b1; addr0 = 12'h410; addr1 = 12'h420;
                #1;
                checks++;
                if (ack0 !== ~grant_pat[i] || ack1 !== grant_pat[i]) begin
                    errors++; $display("FAIL rif_pre_ack cyc %0d got %0b%0b exp %0b%0b", i, ack1, ack0, grant_pat[i], ~grant_pat[i]);
                end
            end else if (i == 3) begin
                sys_rst = 1'b1;
                #1;
                checks++;
                if (ack0 !== 1'b0 || ack1 !== 1'b0) begin
                    errors++; $display("FAIL rif_rst_ack got %0b%0b exp 00", ack1, ack0);
                end
            end else if (i == 4) begin
                sys_rst = 1'b0; addr0 = 12'h4A0; addr1 = 12'h4B0;
                #1;
                checks++;
                if (ack0 !== 1'b1 || ack1 !== 1'b0) begin
                    errors++; $display("FAIL rif_post_tie got ack0=%0b ack1=%0b exp 1 0", ack0, ack1);
                end
            end else begin
                req0 = 1'b0; req1 = 1'b0;
            end
        end
    endtask

`ifdef SPRITE_ARB_CHAR_PRIORITY_EN
    task automatic test_char_priority();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk);
            req0 = 1'b1; req1 = 1'b1; addr0 = 12'h500; addr1 = 12'h600;
            #1;
            checks++;
            if (ack0 !== ~grant_pat[i] || ack1 !== grant_pat[i]) begin
                errors++; $display("FAIL prio_ack cyc %0d got %0b%0b exp %0b%0b", i, ack1, ack0, grant_pat[i], ~grant_pat[i]);
            end
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge sys_clk);
            req0 = 1'b0; req1 = 1'b0;
        end
    endtask
`endif

    task automatic test_drop_req();
        logic t6_gp;
`ifdef SPRITE_ARB_CHAR_PRIORITY_EN
        t6_gp = 1'b0;
`else
        t6_gp = 1'b1;
`endif
        do_reset();
        for (int i = 0; i < 11; i++) begin
            @(negedge sys_clk);
            checks++;
            if (rvalid0 !== (ev[i] & ~ep[i]) || rvalid1 !== (ev[i] & ep[i])) begin
                errors++; $display("FAIL drop_rvalid cyc %0d got v0=%0b v1=%0b exp v0=%0b v1=%0b", i, rvalid0, rvalid1, ev[i] & ~ep[i], ev[i] & ep[i]);
            end
            if (ev[i]) begin
                checks++;
                if ((ep[i] ? rdata1 : rdata0) !== ed[i]) begin
                    errors++; $display("FAIL drop_rdata cyc %0d got %h exp %h", i, (ep[i] ? rdata1 : rdata0), ed[i]);
                end
            end
            if (i < 3) begin
                req0 = 1'b1; req1 = (i != 1); addr0 = 12'h300 + 12'(i); addr1 = 12'h3F0;
                #1;
                checks++;
                if (i < 2) begin
                    if (ack0 !== 1'b1 || ack1 !== 1'b0) begin
                        errors++; $display("FAIL drop_ack cyc %0d got ack0=%0b ack1=%0b exp 1 0", i, ack0, ack1);
                    end
                    ev[i + RL + 3] = 1'b1; ep[i + RL + 3] = 1'b0; ed[i + RL + 3] = rom_fn(12'h300 + 12'(i));
                end else begin
                    if (ack0 !== ~t6_gp || ack1 !== t6_gp) begin
                        errors++; $display("FAIL drop_tie got ack0=%0b ack1=%0b exp %0b %0b", ack0, ack1, ~t6_gp, t6_gp);
                    end
                    ev[i + RL + 3] = 1'b1; ep[i + RL + 3] = t6_gp;
                    ed[i + RL + 3] = rom_fn(t6_gp ? 12'h3F0 : 12'h302);
                end
            end else begin
                req0 = 1'b0; req1 = 1'b0;
            end
        end
    endtask

    initial begin
`ifdef SPRITE_ARB_CHAR_PRIORITY_EN
        grant_pat = 10'b10_0001_0000;
`else
        grant_pat = 10'b10_1010_1010;
`endif
        clear_exp();
        test_reset();
        test_single_read();
        test_round_robin();
        test_latency_sweep();
        test_reset_in_flight();
`ifdef SPRITE_ARB_CHAR_PRIORITY_EN
        test_char_priority();
`endif
        test_drop_req();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule
